decode_instr_window: RTL and testbench

Byte-stream instruction window buffer that sits directly upstream of the operand-signal decoder. It accepts raw instruction bytes one per cycle, strips legacy prefix bytes at the head of the instruction and latches the prefix flags. It then presents a 72-bit little-endian window (`unescaped_instr`) plus `prefix_address_16bit` to the decoder. The buffer releases each instruction's bytes when the downstream length logic reports the consumed length.

---
 rtl/decode_instr_window.sv | 177 +++++++++++++++++
 tb/tb_decode_instr_window.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_instr_window.sv
`default_nettype none
// decode_instr_window: circular byte buffer that strips legacy prefixes and
// presents a 9-byte little-endian instruction window to the decoder.
// Revision 1.0
module decode_instr_window #(
  parameter int DEPTH      = 16,
  parameter int MAX_PREFIX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  output logic        in_ready,
  output logic        instr_valid,
  output logic [71:0] unescaped_instr,
  output logic        prefix_address_16bit,
  output logic        prefix_operand_16bit,
  output logic        prefix_lock,
  output logic [1:0]  prefix_rep,
  output logic [2:0]  prefix_seg,
  input  logic        consume_valid,
  input  logic [3:0]  consume_len,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(MAX_PREFIX + 2);

  typedef enum logic [1:0] {
    S_STRIP = 2'd0,
    S_READY = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_count;
  logic          r_eos;
  logic          r_addr16;
  logic          r_op16;
  logic          r_lock;
  logic [1:0]    r_rep;
  logic [2:0]    r_seg;
  logic [PW-1:0] r_pcnt;

  logic [7:0]    w_head;
  logic          w_is_prefix;
  logic          w_push;
  logic          w_strip;
  logic          w_clr;
  logic [3:0]    w_pop_amt;
  logic          w_len_ok;

  assign w_head   = r_mem[r_rd];
  assign in_ready = (r_count < (AW+1)'(DEPTH)) && (r_state != S_ERROR) && !r_eos;
  assign w_push   = in_valid && in_ready;
  assign w_len_ok = (consume_len != 4'd0) && (consume_len <= 4'd9) &&
                    ((AW+1)'(consume_len) <= r_count);

  always_comb begin
    w_is_prefix = 1'b1;
    case (w_head)
      8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65,
      8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3: w_is_prefix = 1'b1;
      default:                           w_is_prefix = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_strip     = 1'b0;
    w_clr       = 1'b0;
    w_pop_amt   = 4'd0;
    case (r_state)
      S_STRIP: begin
        if (r_count != '0) begin
          if (w_is_prefix) begin
            // A prefix beyond the legal run length is a fault, not a pop.
            if (r_pcnt == PW'(MAX_PREFIX)) begin
              w_state_nxt = S_ERROR;
            end else begin
              w_strip   = 1'b1;
              w_pop_amt = 4'd1;
            end
          end else if ((r_count >= (AW+1)'(9)) || r_eos) begin
            w_state_nxt = S_READY;
          end
        end
      end
      S_READY: begin
        if (consume_valid) begin
          if (w_len_ok) begin
            w_pop_amt   = consume_len;
            w_clr       = 1'b1;
            w_state_nxt = S_STRIP;
          end else begin
            w_state_nxt = S_ERROR;
          end
        end
      end
      default: w_state_nxt = S_ERROR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_STRIP;
      r_rd     <= '0;
      r_wr     <= '0;
      r_count  <= '0;
      r_eos    <= 1'b0;
      r_addr16 <= 1'b0;
      r_op16   <= 1'b0;
      r_lock   <= 1'b0;
      r_rep    <= 2'b00;
      r_seg    <= 3'd0;
      r_pcnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) begin
        r_wr <= r_wr + AW'(1);
        if (in_last) r_eos <= 1'b1;
      end
      r_rd    <= r_rd + AW'(w_pop_amt);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop_amt);
      if (w_clr) begin
        r_addr16 <= 1'b0;
        r_op16   <= 1'b0;
        r_lock   <= 1'b0;
        r_rep    <= 2'b00;
        r_seg    <= 3'd0;
        r_pcnt   <= '0;
      end else if (w_strip) begin
        r_pcnt <= r_pcnt + PW'(1);
        case (w_head)
          8'h67:   r_addr16 <= 1'b1;
          8'h66:   r_op16   <= 1'b1;
          8'hF0:   r_lock   <= 1'b1;
          8'hF3:   r_rep    <= 2'b01;
          8'hF2:   r_rep    <= 2'b10;
          8'h26:   r_seg    <= 3'd1;
          8'h2E:   r_seg    <= 3'd2;
          8'h36:   r_seg    <= 3'd3;
          8'h3E:   r_seg    <= 3'd4;
          8'h64:   r_seg    <= 3'd5;
          8'h65:   r_seg    <= 3'd6;
          default: ;
        endcase
      end
    end
  end

  // Storage needs no reset: stale entries are masked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= in_byte;
  end

  for (genvar k = 0; k < 9; k++) begin : g_win
    logic [AW-1:0] w_idx;
    assign w_idx = r_rd + AW'(k);
    assign unescaped_instr[8*k+7:8*k] = ((AW+1)'(k) < r_count) ? r_mem[w_idx] : 8'h00;
  end

  assign instr_valid          = (r_state == S_READY);
  assign err                  = (r_state == S_ERROR);
  assign prefix_address_16bit = r_addr16;
  assign prefix_operand_16bit = r_op16;
  assign prefix_lock          = r_lock;
  assign prefix_rep           = r_rep;
  assign prefix_seg           = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_decode_instr_window.sv
`default_nettype none
// tb_decode_instr_window: directed scenarios plus a randomized instruction
// stream checked against a stream-level reference model.
module tb_decode_instr_window;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        instr_valid;
  logic [71:0] unescaped_instr;
  logic        prefix_address_16bit;
  logic        prefix_operand_16bit;
  logic        prefix_lock;
  logic [1:0]  prefix_rep;
  logic [2:0]  prefix_seg;
  logic        consume_valid = 1'b0;
  logic [3:0]  consume_len = 4'd0;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_push   = 0;

  logic [7:0] stream[$];
  int         inst_start[$];
  int         inst_np[$];
  int         inst_bl[$];
  logic [7:0] pool [11] = '{8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65,
                            8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3};

  decode_instr_window #(.DEPTH(16), .MAX_PREFIX(4)) u_dut (
    .clk                  (clk),
    .rst                  (rst),
    .in_valid             (in_valid),
    .in_byte              (in_byte),
    .in_last              (in_last),
    .in_ready             (in_ready),
    .instr_valid          (instr_valid),
    .unescaped_instr      (unescaped_instr),
    .prefix_address_16bit (prefix_address_16bit),
    .prefix_operand_16bit (prefix_operand_16bit),
    .prefix_lock          (prefix_lock),
    .prefix_rep           (prefix_rep),
    .prefix_seg           (prefix_seg),
    .consume_valid        (consume_valid),
    .consume_len          (consume_len),
    .err                  (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (in_valid && in_ready) n_push <= n_push + 1;
  end

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    in_valid      = 1'b0;
    in_last       = 1'b0;
    consume_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] b, input logic last);
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic consume(input logic [3:0] len);
    consume_valid = 1'b1;
    consume_len   = len;
    @(negedge clk);
    consume_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!instr_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_valid"}, 72'(instr_valid), 72'd1);
  endtask

  function automatic logic is_pfx(input logic [7:0] b);
    for (int i = 0; i < 11; i++) if (pool[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  // Expected flag vector {a16, o16, lock, rep[1:0], seg[2:0]} of one instruction.
  function automatic logic [7:0] exp_flags(input int start, input int np);
    logic a16 = 0, o16 = 0, lck = 0;
    logic [1:0] rep = 0;
    logic [2:0] seg = 0;
    for (int j = start; j < start + np; j++) begin
      case (stream[j])
        8'h67: a16 = 1;
        8'h66: o16 = 1;
        8'hF0: lck = 1;
        8'hF3: rep = 2'b01;
        8'hF2: rep = 2'b10;
        8'h26: seg = 3'd1;
        8'h2E: seg = 3'd2;
        8'h36: seg = 3'd3;
        8'h3E: seg = 3'd4;
        8'h64: seg = 3'd5;
        8'h65: seg = 3'd6;
        default: ;
      endcase
    end
    return {a16, o16, lck, rep, seg};
  endfunction

  function automatic logic [7:0] dut_flags();
    return {prefix_address_16bit, prefix_operand_16bit, prefix_lock, prefix_rep, prefix_seg};
  endfunction

  initial begin
    int base;
    int n_inst;
    logic [7:0] b;

    do_reset();
    check_eq("rst_valid", 72'(instr_valid), 72'd0);
    check_eq("rst_err", 72'(err), 72'd0);
    check_eq("rst_win", unescaped_instr, 72'd0);
    check_eq("rst_ready", 72'(in_ready), 72'd1);
    check_eq("rst_flags", 72'(dut_flags()), 72'd0);

    // Plain instruction
    push(8'h01, 0);
    push(8'hC8, 0);
    for (int i = 0; i < 7; i++) push(8'h10 + 8'(i), 0);
    check_eq("plain_not_yet", 72'(instr_valid), 72'd0);
    @(negedge clk);
    check_eq("plain_valid", 72'(instr_valid), 72'd1);
    check_eq("plain_win", 72'(unescaped_instr[15:0]), 72'h0C801);
    check_eq("plain_flags", 72'(dut_flags()), 72'd0);
    consume(4'd2);
    check_eq("plain_after_valid", 72'(instr_valid), 72'd0);
    check_eq("plain_after_head", 72'(unescaped_instr[7:0]), 72'h10);

    // Prefixed instruction
    do_reset();
    push(8'h67, 0); push(8'h66, 0); push(8'hF3, 0); push(8'h2E, 0);
    push(8'h8B, 0); push(8'h04, 0); push(8'h24, 0);
    for (int i = 0; i < 6; i++) push(8'h20 + 8'(i), 0);
    wait_valid("pfx");
    check_eq("pfx_a16", 72'(prefix_address_16bit), 72'd1);
    check_eq("pfx_o16", 72'(prefix_operand_16bit), 72'd1);
    check_eq("pfx_lock", 72'(prefix_lock), 72'd0);
    check_eq("pfx_rep", 72'(prefix_rep), 72'd1);
    check_eq("pfx_seg", 72'(prefix_seg), 72'd2);
    check_eq("pfx_win", 72'(unescaped_instr[23:0]), 72'h24048B);
    consume(4'd3);
    check_eq("pfx_cleared", 72'(dut_flags()), 72'd0);

    // Prefix overflow
    do_reset();
    for (int i = 0; i < 5; i++) push(8'h66, 0);
    repeat (3) @(negedge clk);
    check_eq("ovf_err", 72'(err), 72'd1);
    check_eq("ovf_ready", 72'(in_ready), 72'd0);
    check_eq("ovf_valid", 72'(instr_valid), 72'd0);
    repeat (5) @(negedge clk);
    check_eq("ovf_sticky", 72'(err), 72'd1);
    do_reset();
    check_eq("ovf_rst_err", 72'(err), 72'd0);
    check_eq("ovf_rst_ready", 72'(in_ready), 72'd1);

    // End of stream
    push(8'hC3, 1);
    wait_valid("eos");
    check_eq("eos_win", unescaped_instr, 72'h0000000000000000C3);
    check_eq("eos_ready", 72'(in_ready), 72'd0);
    consume(4'd1);
    check_eq("eos_after_valid", 72'(instr_valid), 72'd0);
    check_eq("eos_after_ready", 72'(in_ready), 72'd0);
    check_eq("eos_after_win", unescaped_instr, 72'd0);
    consume(4'd1);
    check_eq("eos_ignored_consume", 72'(err), 72'd0);

    // Full buffer with simultaneous consume, then write-pointer wrap
    do_reset();
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i), 0);
    check_eq("full_ready", 72'(in_ready), 72'd0);
    in_valid = 1'b1; in_byte = 8'hA0;
    consume(4'd3);
    check_eq("full_pop_ready", 72'(in_ready), 72'd1);
    check_eq("full_pop_head", 72'(unescaped_instr[7:0]), 72'h83);
    @(negedge clk); in_byte = 8'hA1;
    @(negedge clk); in_byte = 8'hA2;
    @(negedge clk); in_valid = 1'b0;
    check_eq("full_again", 72'(in_ready), 72'd0);
    wait_valid("full_r2");
    consume(4'd9);
    push(8'hA3, 1);
    wait_valid("wrap");
    check_eq("wrap_win", unescaped_instr, 72'h00A3A2A1A08F8E8D8C);
    consume(4'd9);
    check_eq("over_len_err", 72'(err), 72'd1);
    check_eq("over_len_valid", 72'(instr_valid), 72'd0);

    // Zero-length consume
    do_reset();
    for (int i = 0; i < 9; i++) push(8'h90 + 8'(i), 0);
    wait_valid("zero");
    consume(4'd0);
    check_eq("zero_len_err", 72'(err), 72'd1);

    // Asynchronous reset mid-STRIP
    do_reset();
    push(8'h66, 0);
    push(8'h90, 0);
    check_eq("arst_pre_o16", 72'(prefix_operand_16bit), 72'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_o16", 72'(prefix_operand_16bit), 72'd0);
    check_eq("arst_win", unescaped_instr, 72'd0);
    check_eq("arst_ready", 72'(in_ready), 72'd1);
    check_eq("arst_valid", 72'(instr_valid), 72'd0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized instruction stream
    for (int i = 0; i < 40; i++) begin
      int np, bl;
      np = $urandom_range(0, 4);
      bl = $urandom_range(1, 9);
      inst_start.push_back(stream.size());
      inst_np.push_back(np);
      inst_bl.push_back(bl);
      for (int j = 0; j < np; j++) stream.push_back(pool[$urandom_range(0, 10)]);
      do b = 8'($urandom_range(0, 255)); while (is_pfx(b));
      stream.push_back(b);
      for (int j = 1; j < bl; j++) stream.push_back(8'($urandom_range(0, 255)));
    end
    n_inst = inst_start.size();
    base   = n_push;
    fork
      begin
        int guard = 0;
        while ((n_push - base) < stream.size() && guard < 5000) begin
          if ($urandom_range(0, 3) != 0) begin
            in_valid = 1'b1;
            in_byte  = stream[n_push - base];
            in_last  = ((n_push - base) == stream.size() - 1);
          end else begin
            in_valid = 1'b0;
            in_last  = 1'b0;
          end
          @(negedge clk);
          guard++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      begin
        int idx = 0;
        int guard = 0;
        while (idx < n_inst && guard < 6000) begin
          @(negedge clk);
          guard++;
          consume_valid = 1'b0;
          if (instr_valid && $urandom_range(0, 2) != 0) begin
            int bs, avail;
            logic [71:0] ew;
            bs    = inst_start[idx] + inst_np[idx];
            avail = (n_push - base) - bs;
            ew    = '0;
            for (int k = 0; k < 9; k++)
              if (k < avail) ew[8*k +: 8] = stream[bs + k];
            check_eq($sformatf("rand_win_%0d", idx), unescaped_instr, ew);
            check_eq($sformatf("rand_flags_%0d", idx), 72'(dut_flags()),
                     72'(exp_flags(inst_start[idx], inst_np[idx])));
            consume_valid = 1'b1;
            consume_len   = 4'(inst_bl[idx]);
            idx++;
          end
        end
        @(negedge clk);
        consume_valid = 1'b0;
        check_eq("rand_all_consumed", 72'(idx), 72'(n_inst));
      end
    join
    repeat (3) @(negedge clk);
    check_eq("rand_err", 72'(err), 72'd0);
    check_eq("rand_idle", 72'(instr_valid), 72'd0);
    check_eq("rand_empty", unescaped_instr, 72'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
